fifo_buffer: RTL
================

# fifo_buffer

Parametrised synchronous FIFO built on a 2**W-deep register array, with full/empty/almost flags, an occupancy counter and sticky error flags. Producer and consumer share one clock. It replaces direct register-file use wherever a stream needs elastic buffering between a writer and a reader. Read timing is either registered (one-cycle latency) or first-word-fall-through (FWFT), selected at compile time.

## Interface
- B, 8, data word width in bits (≥1)
- W, 2, address bits; depth = 2**W words (W ≥ 1)
- AF_MARGIN, 1, almost_full asserted when count ≥ 2**W − AF_MARGIN (1 ≤ AF_MARGIN < 2**W)
- AE_MARGIN, 1, almost_empty asserted when count ≤ AE_MARGIN (0 ≤ AE_MARGIN < 2**W)

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- wr  in  1  write request
- w_data  in  B  write data, sampled with wr
- rd  in  1  read request (pop)
- r_data  out  B  read data
- full  out  1  count == 2**W
- empty  out  1  count == 0
- almost_full  out  1  see AF_MARGIN
- almost_empty  out  1  see AE_MARGIN
- count  out  W+1  words stored, 0..2**W
- overflow  out  1  sticky: write rejected because full
- underflow  out  1  sticky: read rejected because empty
- err_clr  in  1  synchronous clear of overflow/underflow

## Operation
- Storage: 2**W × B register array; W-bit write pointer wp and read pointer rp, each wrapping 2**W−1 → 0.
- Write accepted (wr_ok) when wr && (!full || rd). On wr_ok: mem[wp] ← w_data, wp ← wp+1.
- Read accepted (rd_ok) when rd && !empty. On rd_ok: rp ← rp+1.
- Full and rd&wr together: both accepted, count unchanged, no overflow.
- Empty and rd&wr together: write accepted, read rejected, underflow set, count → 1.
- wr && full && !rd: write dropped, memory/pointers unchanged, overflow ← 1.
- rd && empty: no pointer change, r_data unchanged, underflow ← 1.
- count: +1 on wr_ok only, −1 on rd_ok only, unchanged on both/neither. Flags decode from registered count/state, never from rd/wr combinationally.
- overflow/underflow: set on event, held until err_clr; err_clr and a new event in the same cycle → flag stays 1.
- No FSM beyond pointer/count state; behaviour fully defined by the rules above.

## Timing
- Reset (rst_n low, asynchronous): wp=rp=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=underflow=0, r_data=0. Memory contents not reset. Reset asserted mid-operation discards all stored words immediately.
- Flags and count reflect an accepted operation from the clock edge that performs it (visible the cycle after wr/rd is sampled).
- Write-to-readable latency: a word written at edge N is poppable (empty=0) after edge N.
- Registered mode: on rd_ok at edge N, r_data shows mem[rp] after edge N; holds value otherwise.
- FWFT mode: see Configuration.
- Throughput: one write and one read per cycle sustained.

## Configuration
- FIFO_FWFT_EN defined: r_data = mem[rp] combinationally; head word visible whenever empty=0 with zero latency, rd acknowledges/pops it; r_data content undefined while empty (reset value still 0 via mem-independent mux while empty). 
- FIFO_FWFT_EN undefined: registered read as in Timing, one-cycle rd-to-data latency, r_data holds between reads.

## Test plan (B=8, W=2, AF_MARGIN=1, AE_MARGIN=1)
- Reset then write 0x11,0x22,0x33,0x44 on consecutive cycles -> count 1,2,3,4; almost_empty drops at count 2; almost_full at 3; full at 4; empty=0 after first edge.
- Full, wr=1 with 0x55, rd=0 -> overflow=1, count stays 4, later reads return 0x11..0x44 in order (registered: each one cycle after rd).
- Full, rd=wr=1 with 0x66 -> count stays 4, no overflow; drain yields 0x22,0x33,0x44,0x66.
- Empty, rd=wr=1 with 0x77 -> underflow=1, count=1, next read returns 0x77; err_clr pulse -> overflow=underflow=0.
- Wrap-around: 10 interleaved write/read pairs with incrementing data -> pointers wrap twice, data returned in order, count never exceeds 1.
- Assert rst_n low mid-burst at count 3 -> outputs take reset values asynchronously; FWFT build: after writing 0xA5, r_data=0xA5 before any rd.

Source files
------------

// File: rtl/fifo_buffer.sv
// Synchronous FIFO on a 2**W-entry register array with occupancy count, almost flags and sticky errors.
// Define FIFO_FWFT_EN for first-word-fall-through reads; otherwise r_data is registered (one-cycle latency).
module fifo_buffer #(
  parameter int B         = 8,
  parameter int W         = 2,
  parameter int AF_MARGIN = 1,
  parameter int AE_MARGIN = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr,
  input  logic [B-1:0] w_data,
  input  logic         rd,
  output logic [B-1:0] r_data,
  output logic         full,
  output logic         empty,
  output logic         almost_full,
  output logic         almost_empty,
  output logic [W:0]   count,
  output logic         overflow,
  output logic         underflow,
  input  logic         err_clr
);
  localparam int         DEPTH   = 1 << W;
  localparam logic [W:0] DEPTH_C = (W+1)'(DEPTH);
  localparam logic [W:0] AF_TH   = (W+1)'(DEPTH - AF_MARGIN);
  localparam logic [W:0] AE_TH   = (W+1)'(AE_MARGIN);

  logic [B-1:0] mem [DEPTH];
  logic [W-1:0] wp, rp;
  logic         wr_ok, rd_ok;

  // Flags come only from the registered count, never from rd/wr.
  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AF_TH);
  assign almost_empty = (count <= AE_TH);

  // A simultaneous pop frees the slot, so a write into a full FIFO is still accepted.
  assign wr_ok = wr && (!full || rd);
  assign rd_ok = rd && !empty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (wr_ok) wp <= wp + 1'b1;
      if (rd_ok) rp <= rp + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr && full && !rd) overflow <= 1'b1;
      else if (err_clr)      overflow <= 1'b0;
      if (rd && empty)       underflow <= 1'b1;
      else if (err_clr)      underflow <= 1'b0;
    end
  end

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wp] <= w_data;
  end

`ifdef FIFO_FWFT_EN
  // Mux forces 0 while empty so stale memory never leaks out.
  assign r_data = empty ? '0 : mem[rp];
`else
  // When full with rd&wr, wp==rp: this read sees the old word before the write lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_data <= '0;
    else if (rd_ok) r_data <= mem[rp];
  end
`endif
endmodule
